// File: rtl/idct_2d_8x8_seq_pkg.sv
// Shared constants, FSM encoding and the Q2.14 IDCT cosine table for idct_2d_8x8_seq.
package idct_2d_8x8_seq_pkg;

    localparam int N         = 8;
    localparam int IDX_W     = 6;
    localparam int FRAC_BITS = 16;
    localparam int COEF_FRAC = 14;
    localparam int COEF_W    = 16;

    localparam logic [31:0] LEVEL_OFFSET = 32'd128 << FRAC_BITS;
    localparam logic [31:0] PIX_MIN      = 32'd0;
    localparam logic [31:0] PIX_MAX      = 32'd255 << FRAC_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROW  = 2'd1,
        ST_COL  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // 0.5*cos(m*pi/16) in Q2.14 for the first quadrant, m = 0..8.
    function automatic logic signed [COEF_W-1:0] cos_half(input logic [3:0] m);
        case (m)
            4'd0:    cos_half = 16'sd8192;
            4'd1:    cos_half = 16'sd8035;
            4'd2:    cos_half = 16'sd7568;
            4'd3:    cos_half = 16'sd6811;
            4'd4:    cos_half = 16'sd5793;
            4'd5:    cos_half = 16'sd4551;
            4'd6:    cos_half = 16'sd3135;
            4'd7:    cos_half = 16'sd1598;
            default: cos_half = 16'sd0;
        endcase
    endfunction

    // K[n][k] = (C(k)/2)*cos((2n+1)k*pi/16), folded onto the first quadrant by symmetry.
    function automatic logic signed [COEF_W-1:0] idct_coef(input logic [2:0] n, input logic [2:0] k);
        logic [6:0] p;
        logic [4:0] m;
        p = 7'({n, 1'b1}) * 7'(k);
        m = p[4:0];
        if (k == 3'd0)  return 16'sd5793;
        if (m <= 5'd8)  return cos_half(m[3:0]);
        if (m <= 5'd16) return -cos_half(4'(5'd16 - m));
        if (m <= 5'd24) return -cos_half(4'(m - 5'd16));
        return cos_half(4'(6'd32 - 6'(m)));
    endfunction

endpackage

// File: rtl/idct_2d_8x8_seq_dot8.sv
// Combinational 8-term signed dot product: Q(DATA_WIDTH-16).16 x Q2.14, rounded back
// to Q.16 and saturated to the signed DATA_WIDTH range. Shared by both IDCT passes.
module idct_dot8
    import idct_2d_8x8_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COEF_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a_i [N],
    input  logic signed [COEF_WIDTH-1:0] b_i [N],
    output logic signed [DATA_WIDTH-1:0] y_o
);

    localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + 4;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(1) <<< (COEF_FRAC - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] scaled;

    // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        acc = '0;
        for (int j = 0; j < N; j++) begin
            acc = acc + ACC_W'(a_i[j]) * ACC_W'(b_i[j]);
        end
        scaled = (acc + ROUND) >>> COEF_FRAC;
        if (scaled > SAT_MAX) begin
            y_o = DATA_WIDTH'(SAT_MAX);
        end else if (scaled < SAT_MIN) begin
            y_o = DATA_WIDTH'(SAT_MIN);
        end else begin
            y_o = DATA_WIDTH'(scaled);
        end
    end

endmodule

// File: rtl/idct_2d_8x8_seq.sv
// Sequential 8x8 2-D IDCT: a row pass then a column pass through one shared idct_dot8.
// Define IDCT_LEVEL_SHIFT_EN for JPEG pixel output (+128.0, clamp to [0.0, 255.0]).
module idct_2d_8x8_seq
    import idct_2d_8x8_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8,
    parameter int COEF_WIDTH = 16
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] data_in_matrix,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] data_out_matrix,
    output logic                                        busy
);

    localparam int               ELEMS    = DATA_DEPTH * DATA_DEPTH;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ELEMS - 1);

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [DATA_WIDTH-1:0]        f_q   [ELEMS];
    logic [DATA_WIDTH-1:0]        t_q   [ELEMS];
    logic [DATA_WIDTH-1:0]        out_q [ELEMS];
    logic signed [DATA_WIDTH-1:0] dot_a [N];
    logic signed [COEF_WIDTH-1:0] dot_b [N];
    logic signed [DATA_WIDTH-1:0] dot_y;
    logic [DATA_WIDTH-1:0]        col_val;
    logic                         accept;

    assign accept = in_valid && (state_q == ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = '0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_ROW;
            ST_ROW: begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_d = ST_COL;
            end
            ST_COL: begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_d = ST_DONE;
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q == ST_ROW) || (state_q == ST_COL);
        out_valid = (state_q == ST_DONE);
    end

    // Row pass walks F[u][*] against K[y][*]; column pass walks T[*][y] against K[x][*].
    always_comb begin
        for (int j = 0; j < N; j++) begin
            if (state_q == ST_COL) begin
                dot_a[j] = t_q[{3'(j), idx_q[2:0]}];
                dot_b[j] = COEF_WIDTH'(idct_coef(idx_q[5:3], 3'(j)));
            end else begin
                dot_a[j] = f_q[{idx_q[5:3], 3'(j)}];
                dot_b[j] = COEF_WIDTH'(idct_coef(idx_q[2:0], 3'(j)));
            end
        end
    end

    idct_dot8 #(
        .DATA_WIDTH(DATA_WIDTH),
        .COEF_WIDTH(COEF_WIDTH)
    ) u_dot8 (
        .a_i(dot_a),
        .b_i(dot_b),
        .y_o(dot_y)
    );

`ifdef IDCT_LEVEL_SHIFT_EN
    logic signed [DATA_WIDTH:0] shifted;

    always_comb begin
        shifted = {dot_y[DATA_WIDTH-1], dot_y} + $signed({1'b0, LEVEL_OFFSET});
        if (shifted < 0) begin
            col_val = DATA_WIDTH'(PIX_MIN);
        end else if (shifted > $signed({1'b0, PIX_MAX})) begin
            col_val = DATA_WIDTH'(PIX_MAX);
        end else begin
            col_val = shifted[DATA_WIDTH-1:0];
        end
    end
`else
    assign col_val = dot_y;
`endif

    // NOTE: F and T are scratch storage fully rewritten before each read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < ELEMS; k++) begin
                f_q[k] <= data_in_matrix[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (state_q == ST_ROW) begin
            t_q[idx_q] <= dot_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < ELEMS; k++) begin
                out_q[k] <= '0;
            end
        end else if (state_q == ST_COL) begin
            out_q[idx_q] <= col_val;
        end
    end

    for (genvar g = 0; g < ELEMS; g++) begin : g_flat
        assign data_out_matrix[g*DATA_WIDTH +: DATA_WIDTH] = out_q[g];
    end

endmodule
